// File: rtl/formula_pkg.sv
// Shared constants for the formula argmin search: default sizes, cost-width
// offset and FSM state encoding.
package formula_pkg;

  localparam int unsigned W_DEF     = 14;
  localparam int unsigned NCAND_DEF = 64;
  localparam int unsigned CW_OFS    = 4;

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/formula_cost.sv
// Stage S1: combinational per-beat cost with optional clamp, registered on
// acceptance.
module formula_cost
  import formula_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter bit          CLAMP = 1'b1
) (
  input  logic                sig,
  input  logic                rst,
  input  logic                load,
  input  logic [W-1:0]        f2sum,
  input  logic [W-1:0]        g2sum,
  input  logic [W-1:0]        wf,
  input  logic [W-1:0]        wg,
  input  logic [W-1:0]        wfg,
  input  logic [W-1:0]        fg,
  output logic                s1_valid,
  output logic [W+CW_OFS-1:0] s1_cost
);

  localparam int unsigned CW = W + CW_OFS;

  logic [CW-1:0] sum_c;
  logic [CW-1:0] cost_c;

  // Four guard bits keep the signed result exact for all operand values.
  always_comb begin
    sum_c  = CW'(f2sum) + CW'(g2sum) + (CW'(wfg) << 1)
           - CW'(wf) - CW'(wg) - (CW'(fg) << 1);
    cost_c = (CLAMP && sum_c[CW-1]) ? '0 : sum_c;
  end

  always_ff @(posedge sig) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cost  <= '0;
    end else begin
      s1_valid <= load;
      if (load) s1_cost <= cost_c;
    end
  end

endmodule

// File: rtl/formula_argmin.sv
// Streams NCAND candidate beats per window and reports the index and value of
// the minimum cost, holding the result until the consumer takes it.
module formula_argmin
  import formula_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned NCAND = NCAND_DEF,
  parameter bit          CLAMP = 1'b1
) (
  input  logic                     sig,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             f2sum,
  input  logic [W-1:0]             g2sum,
  input  logic [W-1:0]             wf,
  input  logic [W-1:0]             wg,
  input  logic [W-1:0]             wfg,
  input  logic [W-1:0]             fg,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(NCAND)-1:0] out_idx,
  output logic [W+CW_OFS-1:0]      out_cost
);

  localparam int unsigned CW = W + CW_OFS;
  localparam int unsigned IW = $clog2(NCAND);
  localparam logic [IW-1:0] LAST = IW'(NCAND - 1);

  logic [1:0]    state;
  logic [1:0]    nxt_state;
  logic [IW-1:0] cnt;
  logic          accept;
  logic          last_beat;
  logic          s1_valid;
  logic [CW-1:0] s1_cost;
  logic [IW-1:0] s1_idx;
  logic          s1_last;
  logic          s2_last;
  logic [CW-1:0] min_cost;
  logic [IW-1:0] min_idx;

  // Gated by rst so the block never advertises readiness during reset.
  assign in_ready  = (state == ST_ACC) && !rst;
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (cnt == LAST);

  formula_cost #(
    .W     (W),
    .CLAMP (CLAMP)
  ) u_cost (
    .sig      (sig),
    .rst      (rst),
    .load     (accept),
    .f2sum    (f2sum),
    .g2sum    (g2sum),
    .wf       (wf),
    .wg       (wg),
    .wfg      (wfg),
    .fg       (fg),
    .s1_valid (s1_valid),
    .s1_cost  (s1_cost)
  );

  always_ff @(posedge sig) begin
    if (rst) state <= ST_ACC;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      ST_ACC:   if (last_beat) nxt_state = ST_DRAIN;
      ST_DRAIN: if (s2_last)   nxt_state = ST_HOLD;
      ST_HOLD:  if (out_ready) nxt_state = ST_ACC;
      default:  nxt_state = ST_ACC;
    endcase
  end

  // Counter saturates at the last index; only the hand-off clears it.
  always_ff @(posedge sig) begin
    if (rst) begin
      cnt     <= '0;
      s1_idx  <= '0;
      s1_last <= 1'b0;
    end else begin
      if (state == ST_HOLD && out_ready) cnt <= '0;
      else if (accept && cnt != LAST)    cnt <= cnt + IW'(1);
      if (accept) begin
        s1_idx  <= cnt;
        s1_last <= (cnt == LAST);
      end
    end
  end

  // Stage S2: strict signed compare keeps the lowest index on ties.
  always_ff @(posedge sig) begin
    if (rst) begin
      min_cost <= '0;
      min_idx  <= '0;
      s2_last  <= 1'b0;
    end else begin
      s2_last <= s1_valid && s1_last;
      if (s1_valid && (s1_idx == '0 || $signed(s1_cost) < $signed(min_cost))) begin
        min_cost <= s1_cost;
        min_idx  <= s1_idx;
      end
    end
  end

  always_ff @(posedge sig) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_cost  <= '0;
    end else begin
      out_valid <= (nxt_state == ST_HOLD);
      if (state == ST_DRAIN && s2_last) begin
        out_idx  <= min_idx;
        out_cost <= min_cost;
      end
    end
  end

endmodule

// File: tb/tb_formula_argmin.sv
// Bench for formula_argmin: clamped and signed instances side by side, checked
// against an arithmetic argmin model.
module tb_formula_argmin;

  localparam int unsigned W     = 14;
  localparam int unsigned NCAND = 4;
  localparam int unsigned CW    = W + 4;
  localparam int unsigned IW    = 2;

  typedef struct {
    int f2, g2, wf, wg, wfg, fg;
  } beat_t;

  logic          sig = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  f2sum, g2sum, wf, wg, wfg, fg;
  logic          in_ready1, in_ready0;
  logic          out_valid1, out_valid0;
  logic [IW-1:0] out_idx1, out_idx0;
  logic [CW-1:0] out_cost1, out_cost0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sig = ~sig;

  formula_argmin #(.W(W), .NCAND(NCAND), .CLAMP(1'b1)) u_dut1 (
    .sig(sig), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .f2sum(f2sum), .g2sum(g2sum), .wf(wf), .wg(wg), .wfg(wfg), .fg(fg),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_idx(out_idx1), .out_cost(out_cost1)
  );

  formula_argmin #(.W(W), .NCAND(NCAND), .CLAMP(1'b0)) u_dut0 (
    .sig(sig), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .f2sum(f2sum), .g2sum(g2sum), .wf(wf), .wg(wg), .wfg(wfg), .fg(fg),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_idx(out_idx0), .out_cost(out_cost0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t mk(input int c);
    beat_t b = '{0, 0, 0, 0, 0, 0};
    if (c >= 0) b.f2 = c;
    else        b.wf = -c;
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    b.f2  = int'($urandom_range(0, 16383));
    b.g2  = int'($urandom_range(0, 16383));
    b.wf  = int'($urandom_range(0, 16383));
    b.wg  = int'($urandom_range(0, 16383));
    b.wfg = int'($urandom_range(0, 16383));
    b.fg  = int'($urandom_range(0, 16383));
    return b;
  endfunction

  function automatic int beat_cost(input beat_t b, input bit clamp);
    int c = b.f2 + b.g2 + 2 * b.wfg - b.wf - b.wg - 2 * b.fg;
    if (clamp && c < 0) c = 0;
    return c;
  endfunction

  task automatic model(input beat_t bs[NCAND], input bit clamp,
                       output logic [31:0] idx, output logic [31:0] cost);
    int best = 0;
    int bi   = 0;
    for (int k = 0; k < NCAND; k++) begin
      int c = beat_cost(bs[k], clamp);
      if (k == 0 || c < best) begin
        best = c;
        bi   = k;
      end
    end
    idx  = 32'(bi);
    cost = 32'(best) & 32'h0003_FFFF;
  endtask

  task automatic drive(input beat_t b);
    f2sum = W'(b.f2);
    g2sum = W'(b.g2);
    wf    = W'(b.wf);
    wg    = W'(b.wg);
    wfg   = W'(b.wfg);
    fg    = W'(b.fg);
  endtask

  task automatic check_result(input string tag, input logic [31:0] i1, input logic [31:0] c1,
                              input logic [31:0] i0, input logic [31:0] c0);
    check({tag, "_valid1"}, 32'(out_valid1), 32'd1);
    check({tag, "_valid0"}, 32'(out_valid0), 32'd1);
    check({tag, "_idx1"}, 32'(out_idx1), i1);
    check({tag, "_cost1"}, 32'(out_cost1), c1);
    check({tag, "_idx0"}, 32'(out_idx0), i0);
    check({tag, "_cost0"}, 32'(out_cost0), c0);
    check({tag, "_ready1"}, 32'(in_ready1), 32'd0);
    check({tag, "_ready0"}, 32'(in_ready0), 32'd0);
  endtask

  // Feeds one window, checks result latency, holds, then releases.
  task automatic run_window(input string tag, input beat_t bs[NCAND],
                            input bit gaps, input int hold_cycles);
    logic [31:0] i1, c1, i0, c0;
    model(bs, 1'b1, i1, c1);
    model(bs, 1'b0, i0, c0);
    for (int k = 0; k < NCAND; k++) begin
      if (gaps) begin
        drive(rnd_beat());
        in_valid = 1'b0;
        @(posedge sig); #1;
      end
      drive(bs[k]);
      in_valid = 1'b1;
      check({tag, "_acc_ready1"}, 32'(in_ready1), 32'd1);
      check({tag, "_acc_ready0"}, 32'(in_ready0), 32'd1);
      @(posedge sig); #1;
      in_valid = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      check({tag, "_drain_valid"}, 32'(out_valid1), 32'd0);
      check({tag, "_drain_ready"}, 32'(in_ready1), 32'd0);
      in_valid = 1'(d);
      drive(rnd_beat());
      @(posedge sig); #1;
    end
    in_valid = 1'b0;
    check_result(tag, i1, c1, i0, c0);
    for (int h = 0; h < hold_cycles; h++) begin
      drive(rnd_beat());
      in_valid = 1'($urandom_range(0, 1));
      @(posedge sig); #1;
      check_result({tag, "_hold"}, i1, c1, i0, c0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge sig); #1;
    out_ready = 1'b0;
    check({tag, "_rel_valid1"}, 32'(out_valid1), 32'd0);
    check({tag, "_rel_valid0"}, 32'(out_valid0), 32'd0);
    check({tag, "_rel_ready1"}, 32'(in_ready1), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    beat_t bs[NCAND];
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(mk(0));
    @(posedge sig); #1;
    @(posedge sig); #1;
    check("rst_valid", 32'(out_valid1), 32'd0);
    check("rst_idx", 32'(out_idx1), 32'd0);
    check("rst_cost", 32'(out_cost1), 32'd0);
    check("rst_ready", 32'(in_ready1), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready1), 32'd1);

    bs = '{mk(50), mk(20), mk(30), mk(20)};
    run_window("basic", bs, 1'b0, 0);

    bs = '{mk(5), mk(-10), mk(7), mk(9)};
    run_window("neg", bs, 1'b0, 0);

    bs = '{mk(40), mk(12), mk(12), mk(3)};
    run_window("hold", bs, 1'b0, 10);

    bs = '{mk(100), mk(100), mk(100), mk(100)};
    run_window("gaps_eq", bs, 1'b1, 0);

    // Reset after two beats of a window must discard it.
    for (int k = 0; k < 2; k++) begin
      drive(mk(1));
      in_valid = 1'b1;
      @(posedge sig); #1;
      in_valid = 1'b0;
    end
    rst = 1'b1;
    @(posedge sig); #1;
    check("midrst_ready", 32'(in_ready1), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge sig); #1;
      check("midrst_valid1", 32'(out_valid1), 32'd0);
      check("midrst_valid0", 32'(out_valid0), 32'd0);
      check("midrst_ready1", 32'(in_ready1), 32'd1);
    end
    bs = '{mk(9), mk(8), mk(7), mk(6)};
    run_window("after_rst", bs, 1'b0, 0);

    for (int w = 0; w < 20; w++) begin
      for (int k = 0; k < NCAND; k++)
        bs[k] = (w % 2 == 1) ? mk(int'($urandom_range(0, 3))) : rnd_beat();
      run_window("rand", bs, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
